// File: rtl/guess_pkg.sv
// rtl/guess_pkg.sv - shared constants, state encoding and helpers for the LED guessing game
package guess_pkg;

  localparam int NLEDS_DEF          = 10;
  localparam int BASE_PERIOD_DEF    = 16;
  localparam int PERIOD_DEC_DEF     = 2;
  localparam int MAX_LEVEL_DEF      = 7;
  localparam int HITS_PER_LEVEL_DEF = 4;
  localparam int LIVES_INIT_DEF     = 3;
  localparam int SCORE_W_DEF        = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_OVER = 2'd3
  } state_e;

  // Wide result so callers can truncate to their own LED count.
  function automatic logic [31:0] onehot(input logic [31:0] idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/guess_round_ctrl_if.sv
// rtl/guess_round_ctrl_if.sv - key/start inputs and LED/status outputs of the round controller
interface guess_round_ctrl_if #(
  parameter int NLEDS   = 10,
  parameter int SCORE_W = 8
);

  logic               start;
  logic [NLEDS-1:0]   G;
  logic [NLEDS-1:0]   LED;
  logic [SCORE_W-1:0] score;
  logic [2:0]         lives;
  logic [2:0]         level;
  logic               hit;
  logic               miss;
  logic               game_over;

  modport master (
    output start, G,
    input  LED, score, lives, level, hit, miss, game_over
  );

  modport slave (
    input  start, G,
    output LED, score, lives, level, hit, miss, game_over
  );

endinterface

// File: rtl/guess_step_timer.sv
// rtl/guess_step_timer.sv - LED step down-counter; step_o is high while the count sits at zero
module guess_step_timer #(
  parameter int TW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  input  logic          freeze_i,
  output logic          step_o
);

  logic [TW-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (!freeze_i && (count_q != '0)) begin
      count_q <= count_q - TW'(1);
    end
  end

  assign step_o = (count_q == '0);

endmodule

// File: rtl/guess_round_ctrl.sv
// rtl/guess_round_ctrl.sv - paces the LED sweep, scores key guesses, tracks lives/level per game
module guess_round_ctrl
  import guess_pkg::*;
#(
  parameter int NLEDS          = NLEDS_DEF,
  parameter int BASE_PERIOD    = BASE_PERIOD_DEF,
  parameter int PERIOD_DEC     = PERIOD_DEC_DEF,
  parameter int MAX_LEVEL      = MAX_LEVEL_DEF,
  parameter int HITS_PER_LEVEL = HITS_PER_LEVEL_DEF,
  parameter int LIVES_INIT     = LIVES_INIT_DEF,
  parameter int SCORE_W        = SCORE_W_DEF
) (
  input logic               clk,
  input logic               reset,
  guess_round_ctrl_if.slave bus
);

  localparam int PW = $clog2(NLEDS);
  localparam int TW = $clog2(BASE_PERIOD + 1);
  localparam int HW = $clog2(HITS_PER_LEVEL + 1);

  state_e             state_q;
  logic [PW-1:0]      pos_q;
  logic [HW-1:0]      hit_cnt_q;
  logic [NLEDS-1:0]   led_q;
  logic [SCORE_W-1:0] score_q;
  logic [2:0]         lives_q;
  logic [2:0]         level_q;
  logic               hit_q;
  logic               miss_q;
  logic               game_over_q;

  logic             guess;
  logic             is_hit;
  logic             start_ok;
  logic             step;
  logic             tmr_load;
  logic             tmr_freeze;
  logic [TW-1:0]    tmr_val;
  logic [PW-1:0]    pos_next;
  logic [NLEDS-1:0] pos_oh;
  logic [NLEDS-1:0] pos_next_oh;

  assign guess       = |bus.G;
  assign pos_oh      = NLEDS'(onehot(32'(pos_q)));
  assign pos_next    = (pos_q == PW'(NLEDS - 1)) ? '0 : pos_q + PW'(1);
  assign pos_next_oh = NLEDS'(onehot(32'(pos_next)));
  assign is_hit      = (bus.G == pos_oh);
  assign start_ok    = bus.start && ((state_q == ST_IDLE) || (state_q == ST_OVER));

  // A new game always starts at level 0; otherwise the period follows the current
  // level, which a hit has already updated by the time HOLD releases.
  assign tmr_val = start_ok ? TW'(BASE_PERIOD - 1)
                            : TW'(BASE_PERIOD - 1 - int'(level_q) * PERIOD_DEC);

  assign tmr_load   = start_ok
                   || ((state_q == ST_RUN)  && !guess && step)
                   || ((state_q == ST_HOLD) && !guess);
  assign tmr_freeze = !((state_q == ST_RUN) && !guess);

  guess_step_timer #(
    .TW(TW)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .freeze_i  (tmr_freeze),
    .step_o    (step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pos_q       <= '0;
      hit_cnt_q   <= '0;
      led_q       <= '0;
      score_q     <= '0;
      lives_q     <= '0;
      level_q     <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (bus.start) begin
            state_q     <= ST_RUN;
            pos_q       <= '0;
            hit_cnt_q   <= '0;
            led_q       <= NLEDS'(onehot(32'd0));
            score_q     <= '0;
            lives_q     <= 3'(LIVES_INIT);
            level_q     <= '0;
            game_over_q <= 1'b0;
          end
        end
        ST_RUN: begin
          // A guess beats a same-cycle timer expiry: pos stays put until release.
          if (guess) begin
            if (is_hit) begin
              hit_q   <= 1'b1;
              state_q <= ST_HOLD;
              if (score_q != '1) score_q <= score_q + SCORE_W'(1);
              if (hit_cnt_q == HW'(HITS_PER_LEVEL - 1)) begin
                hit_cnt_q <= '0;
                if (level_q != 3'(MAX_LEVEL)) level_q <= level_q + 3'd1;
              end else begin
                hit_cnt_q <= hit_cnt_q + HW'(1);
              end
            end else begin
              miss_q <= 1'b1;
              if (lives_q == 3'd1) begin
                lives_q     <= 3'd0;
                state_q     <= ST_OVER;
                led_q       <= '1;
                game_over_q <= 1'b1;
              end else begin
                lives_q <= lives_q - 3'd1;
                state_q <= ST_HOLD;
              end
            end
          end else if (step) begin
            pos_q <= pos_next;
            led_q <= pos_next_oh;
          end
        end
        ST_HOLD: begin
          if (!guess) begin
            state_q <= ST_RUN;
            pos_q   <= pos_next;
            led_q   <= pos_next_oh;
          end
        end
      endcase
    end
  end

  assign bus.LED       = led_q;
  assign bus.score     = score_q;
  assign bus.lives     = lives_q;
  assign bus.level     = level_q;
  assign bus.hit       = hit_q;
  assign bus.miss      = miss_q;
  assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_guess_round_ctrl.sv
// tb/tb_guess_round_ctrl.sv - directed vector table plus hand sequences for guess_round_ctrl
module tb_guess_round_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   ntot = 0;
  int   npass = 0;
  int   nhit = 0;
  int   nmiss = 0;
  int   nbad = 0;
  logic prev_hit = 1'b0;
  logic prev_miss = 1'b0;
  int   tp;
  int   per;

  guess_round_ctrl_if #(.NLEDS(10), .SCORE_W(8)) bus ();

  guess_round_ctrl #(
    .NLEDS(10), .BASE_PERIOD(16), .PERIOD_DEC(2), .MAX_LEVEL(7),
    .HITS_PER_LEVEL(4), .LIVES_INIT(3), .SCORE_W(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.hit) nhit++;
    if (bus.miss) nmiss++;
    if (bus.hit && bus.miss) nbad++;
    if ((bus.hit && prev_hit) || (bus.miss && prev_miss)) nbad++;
    prev_hit  = bus.hit;
    prev_miss = bus.miss;
  end

  typedef struct {
    logic       start;
    logic [9:0] g;
    int         n;
    logic [9:0] led;
    logic [7:0] score;
    logic [2:0] lives;
    logic [2:0] level;
    logic       hit;
    logic       miss;
    logic       over;
  } vec_t;

  localparam int NV = 11;
  vec_t vt [NV];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [9:0] oh(input int p);
    return 10'd1 << p;
  endfunction

  task automatic chk_all(input string nm, input logic [9:0] led, input logic [7:0] score,
                         input logic [2:0] lives, input logic [2:0] level,
                         input logic h, input logic m, input logic o);
    chk({nm, "_led"}, 32'(bus.LED), 32'(led));
    chk({nm, "_score"}, 32'(bus.score), 32'(score));
    chk({nm, "_lives"}, 32'(bus.lives), 32'(lives));
    chk({nm, "_level"}, 32'(bus.level), 32'(level));
    chk({nm, "_hit"}, 32'(bus.hit), 32'(h));
    chk({nm, "_miss"}, 32'(bus.miss), 32'(m));
    chk({nm, "_over"}, 32'(bus.game_over), 32'(o));
  endtask

  task automatic do_press(input string nm, input logic [9:0] key, input logic eh,
                          input logic em, input logic [2:0] el);
    bus.G = key;
    tick(1);
    chk({nm, "_hit"}, 32'(bus.hit), 32'(eh));
    chk({nm, "_miss"}, 32'(bus.miss), 32'(em));
    chk({nm, "_lives"}, 32'(bus.lives), 32'(el));
    bus.G = '0;
    tick(1);
  endtask

  // Ticks until the LED changes, then counts how long the new pattern lasts.
  task automatic measure(output int p);
    logic [9:0] l0;
    int c;
    l0 = bus.LED;
    c = 0;
    while (bus.LED == l0 && c < 100) begin tick(1); c++; end
    l0 = bus.LED;
    p = 0;
    while (bus.LED == l0 && p < 100) begin tick(1); p++; end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.G     = '0;

    vt[0]  = '{1'b1, 10'h000,  1, 10'h001, 8'd0, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 10'h000, 15, 10'h001, 8'd0, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 10'h000,  1, 10'h002, 8'd0, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 10'h000, 15, 10'h002, 8'd0, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 10'h000,  1, 10'h004, 8'd0, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 10'h004,  1, 10'h004, 8'd1, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 10'h004,  4, 10'h004, 8'd1, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 10'h000,  1, 10'h008, 8'd1, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 10'h000, 96, 10'h200, 8'd1, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 10'h000, 15, 10'h200, 8'd1, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0};
    vt[10] = '{1'b0, 10'h000,  1, 10'h001, 8'd1, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0};

    #1 reset = 1'b1;
    tick(2);
    chk_all("reset", 10'h000, 8'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick(1);
    chk_all("idle", 10'h000, 8'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      bus.start = vt[i].start;
      bus.G     = vt[i].g;
      tick(vt[i].n);
      chk_all($sformatf("v%0d", i), vt[i].led, vt[i].score, vt[i].lives, vt[i].level,
              vt[i].hit, vt[i].miss, vt[i].over);
    end
    bus.start = 1'b0;
    bus.G     = '0;
    tp = 0;

    for (int i = 0; i < 3; i++) begin
      do_press($sformatf("l1_h%0d", i), oh(tp), 1'b1, 1'b0, 3'd3);
      tp = (tp + 1) % 10;
    end
    chk("l1_level", 32'(bus.level), 32'd1);
    chk("l1_score", 32'(bus.score), 32'd4);
    measure(per);
    chk("l1_period", 32'(per), 32'd14);
    tp = (tp + 2) % 10;

    for (int i = 0; i < 24; i++) begin
      do_press($sformatf("up_h%0d", i), oh(tp), 1'b1, 1'b0, 3'd3);
      tp = (tp + 1) % 10;
    end
    chk("l7_level", 32'(bus.level), 32'd7);
    chk("l7_score", 32'(bus.score), 32'd28);
    for (int i = 0; i < 4; i++) begin
      do_press($sformatf("sat_h%0d", i), oh(tp), 1'b1, 1'b0, 3'd3);
      tp = (tp + 1) % 10;
    end
    chk("sat_level", 32'(bus.level), 32'd7);
    chk("sat_score", 32'(bus.score), 32'd32);
    measure(per);
    chk("l7_period", 32'(per), 32'd2);
    tp = (tp + 2) % 10;

    // Timer reaches zero on the same cycle the key goes down.
    tick(1);
    chk("t0_pre_led", 32'(bus.LED), 32'(oh(tp)));
    bus.G = oh(tp);
    tick(1);
    chk("t0_hit", 32'(bus.hit), 32'd1);
    chk("t0_hold_led", 32'(bus.LED), 32'(oh(tp)));
    tick(1);
    chk("t0_frozen_led", 32'(bus.LED), 32'(oh(tp)));
    chk("t0_one_pulse", 32'(bus.hit), 32'd0);
    bus.G = '0;
    tick(1);
    tp = (tp + 1) % 10;
    chk("t0_resume_led", 32'(bus.LED), 32'(oh(tp)));
    chk("t0_score", 32'(bus.score), 32'd33);

    do_press("miss1", oh((tp + 5) % 10), 1'b0, 1'b1, 3'd2);
    tp = (tp + 1) % 10;
    do_press("miss2", 10'h003, 1'b0, 1'b1, 3'd1);
    tp = (tp + 1) % 10;
    bus.G = 10'h300;
    tick(1);
    chk_all("miss3", 10'h3ff, 8'd33, 3'd0, 3'd7, 1'b0, 1'b1, 1'b1);
    bus.G = '0;
    tick(2);
    chk_all("over", 10'h3ff, 8'd33, 3'd0, 3'd7, 1'b0, 1'b0, 1'b1);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    chk_all("restart", 10'h001, 8'd0, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0);

    bus.G = 10'h001;
    tick(1);
    chk("rst_pre_hit", 32'(bus.hit), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk_all("rst_async", 10'h000, 8'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    tick(2);
    chk_all("rst_held", 10'h000, 8'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    bus.G = '0;
    tick(2);
    chk_all("rst_idle", 10'h000, 8'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);

    chk("hit_pulses", 32'(nhit), 32'd33);
    chk("miss_pulses", 32'(nmiss), 32'd3);
    chk("pulse_rules", 32'(nbad), 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
